// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result handshake bundle for add_pipe.
//   in_valid/in_ready   operand transfer handshake
//   a, b, sub, cin      operands and operation select (sampled on transfer)
//   out_valid/out_ready result transfer handshake
//   sum, cout           result and carry-out / no-borrow
//   ovf, zr, ng         status flags, present only with ADD_PIPE_FLAGS_EN
// Modports: master = operand producer / result consumer, slave = add_pipe.
interface add_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADD_PIPE_FLAGS_EN
  logic             ovf;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zr, ng
  );
  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zr, ng
  );
`else
  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/add_pipe.sv
// add_pipe: pipelined adder/subtractor, one SLICE-bit slice resolved per stage
// with the carry registered between stages. STAGES = WIDTH/SLICE, latency
// STAGES cycles, one result per clock, per-stage valid/ready backpressure.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    add_pipe_if.slave (operand handshake in, result handshake out)
// Optional feature: define ADD_PIPE_FLAGS_EN to add ovf/zr/ng status flags
// registered alongside the result.
// SLICE must divide WIDTH.
module add_pipe #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic       clk,
  input logic       rst_n,
  add_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SLICE;
  // Inter-stage registers exist only between stages; keep at least one entry
  // so the arrays stay legal for the single-stage build.
  localparam int SKEW = (STAGES > 1) ? STAGES - 1 : 1;

  // Per-stage inputs: either the bus (stage 0) or the previous stage's regs.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];
  logic [STAGES:0]  rdy;

  // Inter-stage registers: operands carried along for the upper slices
  // still to be resolved, completed low sum bits, and the slice carry.
  logic [WIDTH-1:0] a_reg [SKEW];
  logic [WIDTH-1:0] b_reg [SKEW];
  logic [WIDTH-1:0] s_reg [SKEW];
  logic             c_reg [SKEW];
  logic             v_reg [STAGES];

  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  assign rdy[STAGES]   = bus.out_ready;
  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_reg[STAGES-1];
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;

`ifdef ADD_PIPE_FLAGS_EN
  logic ovf_reg;
  logic zr_reg;
  logic ng_reg;

  assign bus.ovf = ovf_reg;
  assign bus.zr  = zr_reg;
  assign bus.ng  = ng_reg;
`endif

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SLICE:0]   slice_sum;
      logic [WIDTH-1:0] sum_next;
      logic             load;

      if (gi == 0) begin : g_src
        // Subtraction is a + ~b + ~borrow_in.
        assign a_in[gi] = bus.a;
        assign b_in[gi] = bus.sub ? ~bus.b : bus.b;
        assign c_in[gi] = bus.sub ^ bus.cin;
        assign s_in[gi] = '0;
        assign v_in[gi] = bus.in_valid;
      end else begin : g_src
        assign a_in[gi] = a_reg[gi-1];
        assign b_in[gi] = b_reg[gi-1];
        assign c_in[gi] = c_reg[gi-1];
        assign s_in[gi] = s_reg[gi-1];
        assign v_in[gi] = v_reg[gi-1];
      end

      assign slice_sum = {1'b0, a_in[gi][gi*SLICE +: SLICE]}
                       + {1'b0, b_in[gi][gi*SLICE +: SLICE]}
                       + {{SLICE{1'b0}}, c_in[gi]};

      always_comb begin
        sum_next = s_in[gi];
        sum_next[gi*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      end

      // A stage can take new data when it is empty or its successor moves;
      // this lets bubbles collapse behind a stalled output.
      assign rdy[gi] = !v_reg[gi] || rdy[gi+1];
      // Data only loads for a real upstream item so bubbles leave it intact.
      assign load    = rdy[gi] && v_in[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg[gi] <= 1'b0;
        end else if (rdy[gi]) begin
          v_reg[gi] <= v_in[gi];
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_reg[gi] <= '0;
            b_reg[gi] <= '0;
            s_reg[gi] <= '0;
            c_reg[gi] <= 1'b0;
          end else if (load) begin
            a_reg[gi] <= a_in[gi];
            b_reg[gi] <= b_in[gi];
            s_reg[gi] <= sum_next;
            c_reg[gi] <= slice_sum[SLICE];
          end
        end
      end else begin : g_out
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
          end else if (load) begin
            sum_reg  <= sum_next;
            cout_reg <= slice_sum[SLICE];
          end
        end

`ifdef ADD_PIPE_FLAGS_EN
        // Signed overflow: operands agree in sign but the result does not.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
            zr_reg  <= 1'b0;
            ng_reg  <= 1'b0;
          end else if (load) begin
            ovf_reg <= (a_in[gi][WIDTH-1] == b_in[gi][WIDTH-1]) &&
                       (sum_next[WIDTH-1] != a_in[gi][WIDTH-1]);
            zr_reg  <= (sum_next == '0);
            ng_reg  <= sum_next[WIDTH-1];
          end
        end
`endif
      end
    end
  endgenerate
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed self-checking bench for add_pipe.
// Two instances: WIDTH=16/SLICE=4 (four stages) and WIDTH=32/SLICE=32
// (single stage). Flag checks are compiled in with ADD_PIPE_FLAGS_EN.
module tb_add_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  add_pipe_if #(.WIDTH(16)) bus16 ();
  add_pipe_if #(.WIDTH(32)) bus32 ();

  add_pipe #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  add_pipe #(.WIDTH(32), .SLICE(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  // Stream vectors: a, b, sub, cin -> sum, cout (hand-computed)
  logic [15:0] sa   [8];
  logic [15:0] sb   [8];
  logic        ssub [8];
  logic        scin [8];
  logic [15:0] ss   [8];
  logic        sco  [8];

  // Back-to-back 32-bit vectors
  logic [31:0] wa   [4];
  logic [31:0] wb   [4];
  logic        wsub [4];
  logic        wcin [4];
  logic [31:0] ws   [4];
  logic        wco  [4];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation on the 16-bit instance; flags = {ovf, zr, ng}.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin, input logic [15:0] exp_sum,
                       input logic exp_cout, input logic [2:0] exp_flags);
    int lat;
    @(negedge clk);
    bus16.a         = a;
    bus16.b         = b;
    bus16.sub       = sub;
    bus16.cin       = cin;
    bus16.in_valid  = 1'b1;
    bus16.out_ready = 1'b1;
    #1;
    check_val({tag, " in_ready"}, 64'(bus16.in_ready), 64'(1));
    @(negedge clk);
    // Scramble operands: they must have been captured at the transfer.
    bus16.in_valid = 1'b0;
    bus16.a        = 16'hDEAD;
    bus16.b        = 16'hBEEF;
    bus16.sub      = ~sub;
    bus16.cin      = ~cin;
    lat = 1;
    while (!bus16.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, " latency"}, 64'(lat), 64'(4));
    check_val({tag, " sum"}, 64'(bus16.sum), 64'(exp_sum));
    check_val({tag, " cout"}, 64'(bus16.cout), 64'(exp_cout));
`ifdef ADD_PIPE_FLAGS_EN
    check_val({tag, " flags"}, 64'({bus16.ovf, bus16.zr, bus16.ng}), 64'(exp_flags));
`endif
    $display("op %s: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b lat=%0d (flags ovf/zr/ng ref %b)",
             tag, a, b, sub, cin, bus16.sum, bus16.cout, lat, exp_flags);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int recv;
    int cyc;
    int lat;
    int seen;
    logic orun;
    logic acc;
    logic emit;

    sa[0] = 16'h1234; sb[0] = 16'h1111; ssub[0] = 0; scin[0] = 0; ss[0] = 16'h2345; sco[0] = 0;
    sa[1] = 16'hFFFF; sb[1] = 16'hFFFF; ssub[1] = 0; scin[1] = 1; ss[1] = 16'hFFFF; sco[1] = 1;
    sa[2] = 16'h8000; sb[2] = 16'h0001; ssub[2] = 1; scin[2] = 0; ss[2] = 16'h7FFF; sco[2] = 1;
    sa[3] = 16'h0000; sb[3] = 16'h0001; ssub[3] = 1; scin[3] = 0; ss[3] = 16'hFFFF; sco[3] = 0;
    sa[4] = 16'hABCD; sb[4] = 16'h1234; ssub[4] = 0; scin[4] = 1; ss[4] = 16'hBE02; sco[4] = 0;
    sa[5] = 16'h1000; sb[5] = 16'h1000; ssub[5] = 1; scin[5] = 1; ss[5] = 16'hFFFF; sco[5] = 0;
    sa[6] = 16'h00FF; sb[6] = 16'h0F01; ssub[6] = 0; scin[6] = 0; ss[6] = 16'h1000; sco[6] = 0;
    sa[7] = 16'hF000; sb[7] = 16'h1000; ssub[7] = 0; scin[7] = 0; ss[7] = 16'h0000; sco[7] = 1;

    wa[0] = 32'h12345678; wb[0] = 32'h11111111; wsub[0] = 0; wcin[0] = 0; ws[0] = 32'h23456789; wco[0] = 0;
    wa[1] = 32'h80000000; wb[1] = 32'h80000000; wsub[1] = 0; wcin[1] = 0; ws[1] = 32'h00000000; wco[1] = 1;
    wa[2] = 32'h0000000A; wb[2] = 32'h00000003; wsub[2] = 1; wcin[2] = 0; ws[2] = 32'h00000007; wco[2] = 1;
    wa[3] = 32'h00000003; wb[3] = 32'h0000000A; wsub[3] = 1; wcin[3] = 1; ws[3] = 32'hFFFFFFF8; wco[3] = 0;

    bus16.in_valid = 0; bus16.out_ready = 0; bus16.a = '0; bus16.b = '0; bus16.sub = 0; bus16.cin = 0;
    bus32.in_valid = 0; bus32.out_ready = 1; bus32.a = '0; bus32.b = '0; bus32.sub = 0; bus32.cin = 0;

    // Reset state
    #12;
    check_val("reset out_valid", 64'(bus16.out_valid), 64'(0));
    check_val("reset sum", 64'(bus16.sum), 64'(0));
    check_val("reset cout", 64'(bus16.cout), 64'(0));
    check_val("reset in_ready", 64'(bus16.in_ready), 64'(1));
`ifdef ADD_PIPE_FLAGS_EN
    check_val("reset flags", 64'({bus16.ovf, bus16.zr, bus16.ng}), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single operations
    run16("add 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 3'b101);
    run16("add ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 3'b010);
    run16("sub 5-7", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 3'b001);
    run16("sub 7-5-1", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 3'b000);

    // Stream with out_ready pattern 1,0,0,1
    sent = 0; recv = 0; cyc = 0;
    while (recv < 8 && cyc < 100) begin
      @(negedge clk);
      orun = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      bus16.out_ready = orun;
      bus16.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus16.a = sa[sent]; bus16.b = sb[sent]; bus16.sub = ssub[sent]; bus16.cin = scin[sent];
      end
      #1;
      // Only a full pipe with a stalled consumer may refuse operands.
      check_val($sformatf("stream in_ready c%0d", cyc), 64'(bus16.in_ready),
                64'(!((sent - recv) == 4 && !orun)));
      acc  = bus16.in_valid && bus16.in_ready;
      emit = bus16.out_valid && bus16.out_ready;
      if (emit) begin
        check_val($sformatf("stream sum #%0d", recv), 64'(bus16.sum), 64'(ss[recv]));
        check_val($sformatf("stream cout #%0d", recv), 64'(bus16.cout), 64'(sco[recv]));
        $display("stream result %0d: sum=%h cout=%b (ref %h %b)", recv, bus16.sum, bus16.cout,
                 ss[recv], sco[recv]);
        recv++;
      end
      if (acc) sent++;
      cyc++;
    end
    check_val("stream result count", 64'(recv), 64'(8));
    @(negedge clk);
    bus16.in_valid = 0;
    bus16.out_ready = 1;
    #1;
    check_val("stream no extra result", 64'(bus16.out_valid), 64'(0));

    // Reset with three ops in flight
    @(negedge clk);
    bus16.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus16.in_valid = 1;
      bus16.a = sa[i]; bus16.b = sb[i]; bus16.sub = ssub[i]; bus16.cin = scin[i];
      @(negedge clk);
    end
    bus16.in_valid = 0;
    @(negedge clk);
    #1;
    check_val("pre-reset out_valid", 64'(bus16.out_valid), 64'(1));
    check_val("pre-reset sum", 64'(bus16.sum), 64'(ss[0]));
    rst_n = 1'b0;
    #1;
    check_val("async reset out_valid", 64'(bus16.out_valid), 64'(0));
    check_val("async reset sum", 64'(bus16.sum), 64'(0));
    check_val("async reset cout", 64'(bus16.cout), 64'(0));
    check_val("async reset in_ready", 64'(bus16.in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    bus16.out_ready = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus16.out_valid) seen++;
    end
    check_val("no stale after reset", 64'(seen), 64'(0));
    $display("reset pulse: stale results seen=%0d", seen);

    // 32-bit single stage: latency 1
    @(negedge clk);
    bus32.a = 32'hFFFFFFFF; bus32.b = 32'h00000000; bus32.sub = 0; bus32.cin = 1;
    bus32.in_valid = 1; bus32.out_ready = 1;
    @(negedge clk);
    bus32.in_valid = 0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val("w32 latency", 64'(lat), 64'(1));
    check_val("w32 sum", 64'(bus32.sum), 64'(0));
    check_val("w32 cout", 64'(bus32.cout), 64'(1));
    $display("w32 op: ffffffff+0+1 -> sum=%h cout=%b lat=%0d", bus32.sum, bus32.cout, lat);

    // 32-bit back-to-back: one result per clock
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      bus32.in_valid = (i < 4);
      if (i < 4) begin
        bus32.a = wa[i]; bus32.b = wb[i]; bus32.sub = wsub[i]; bus32.cin = wcin[i];
      end
      #1;
      if (i > 0) begin
        check_val($sformatf("w32 b2b valid #%0d", i - 1), 64'(bus32.out_valid), 64'(1));
        check_val($sformatf("w32 b2b sum #%0d", i - 1), 64'(bus32.sum), 64'(ws[i-1]));
        check_val($sformatf("w32 b2b cout #%0d", i - 1), 64'(bus32.cout), 64'(wco[i-1]));
        $display("w32 b2b %0d: sum=%h cout=%b (ref %h %b)", i - 1, bus32.sum, bus32.cout,
                 ws[i-1], wco[i-1]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined adder/subtractor for the datapath, generalising the 16-bit ripple-carry adder to any width. Operands are split into equal slices; one slice resolves per pipeline stage, with carry forwarded stage to stage. The block uses a valid/ready handshake with per-stage backpressure and sustains one operation per clock. It feeds the ALU and address paths where a full-width ripple carry would not meet timing.

## Interface
- WIDTH, 16, operand/result width in bits; ≥ 2
- SLICE, 4, bits resolved per stage; must divide WIDTH; STAGES = WIDTH/SLICE
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transfer request
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = add, 1 = subtract
- cin  in  1  carry-in (add) / borrow-in (subtract)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out (add); no-borrow (subtract, 1 = no borrow)
- ovf, zr, ng  out  1 each  status flags, only with ADD_PIPE_FLAGS_EN

## Operation
- Arithmetic: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin; {cout, sum} = a + b_eff + c0, modulo 2^WIDTH with cout as bit WIDTH.
- Add: a+b+cin. Subtract: a−b−cin; cout=0 means a borrow occurred.
- Stage k (0..STAGES−1) computes sum bits [k·SLICE +: SLICE] from registered carry of stage k−1 (stage 0 uses c0).
- Each stage registers: valid v[k], its carry, completed low sum bits, and the unprocessed upper slices of a and b_eff (skew buffering).
- Handshake: transfer on in_valid && in_ready, and on out_valid && out_ready.
- Per-stage flow: r[STAGES] = out_ready; r[k] = !v[k] || r[k+1]; in_ready = r[0]. Stage k loads from stage k−1 when r[k]; v[k] takes the upstream valid.
- A stalled stage holds its contents; bubbles collapse behind a stall.
- Results emerge in acceptance order; none dropped or duplicated.
- out_valid = v[STAGES−1]; sum, cout come from the last stage register.
- in_valid low with in_ready high inserts a bubble.
- Inputs are sampled only on transfer; changes while not transferring are ignored.

## Timing
- Reset (rst_n low, async): all v[k]=0, all data/carry registers 0; out_valid=0, sum=0, cout=0, flags=0. in_ready reads 1 combinationally after reset.
- Reset mid-operation discards all in-flight results; no output after release until new operands are accepted.
- Latency: operands accepted at edge n → out_valid=1 after edge n+STAGES−1 (STAGES cycles counting the accept cycle); SLICE=WIDTH gives single-stage latency 1.
- Throughput: 1 result/clk with out_ready held high.
- Full pipe with out_ready=0: in_ready=0.
- Full pipe with out_ready=1: accept and emit in the same cycle.
- in_ready depends combinationally on out_ready (ripple through stage valids); out_valid, sum, cout, flags are registered.

## Configuration
- ADD_PIPE_FLAGS_EN defined:
  - ovf = signed overflow; add: a[MSB]==b_eff[MSB] && sum[MSB]!=a[MSB].
  - zr = (sum==0); ng = sum[MSB].
  - Computed in the last stage, registered with sum, reset 0.
- Undefined: ovf/zr/ng ports and their logic absent; all other behaviour identical.

## Test plan
- WIDTH=16, SLICE=4, add 0x7FFF+0x0001, cin=0 → after 4 cycles sum=0x8000, cout=0; flags: ovf=1, ng=1, zr=0.
- Add 0xFFFF+0x0001 → sum=0x0000, cout=1; flags: zr=1, ovf=0.
- Sub 0x0005−0x0007, cin=0 → sum=0xFFFE, cout=0; flags: ng=1. Sub 0x0007−0x0005, cin=1 → sum=0x0001, cout=1.
- Stream of 8 random ops with in_valid held high and out_ready toggling 1,0,0,1,…:
  - results match the reference model in order, with no loss or duplication;
  - in_ready=0 only when all 4 stages are valid and out_ready=0.
- Reset pulse with 3 ops in flight:
  - out_valid, sum and cout drop to 0 immediately;
  - no stale results appear after release.
- WIDTH=32, SLICE=32:
  - 0xFFFFFFFF+0x00000000, cin=1 → sum=0, cout=1 one cycle after accept;
  - back-to-back ops give 1 result/clk.
